// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and state type for the mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_arbiter_if.sv
// mux_arb_if: request/grant and mux-alignment signals between requesters and arbiter
interface mux_arb_if;
  import mux_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] out_src;
  logic busy;
  logic out_valid;
  modport slave(input req, output gnt, sel, busy, out_valid, out_src);
  modport master(output req, input gnt, sel, busy, out_valid, out_src);
endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: first set request searching upward from last+1 with wrap-around
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  // scan farthest-first so the nearest candidate after last overwrites the rest
  always_comb begin
    found = 1'b0;
    idx = last;
    for (int k = N_REQ; k >= 1; k--)
      if (req[last + SEL_W'(k)]) begin
        found = 1'b1;
        idx = last + SEL_W'(k);
      end
  end
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin burst arbiter driving the select of a registered 4:1 mux
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input logic      clk,
  input logic      rst,
  mux_arb_if.slave bus
);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  state_t r_state, w_state;
  logic [SEL_W-1:0] r_owner, w_owner, r_last, w_last, r_sel, w_sel, r_out_src, w_idx;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic r_out_valid, w_found, w_beat, w_arb;
  rr_pick u_pick (.req(bus.req), .last(r_last), .found(w_found), .idx(w_idx));
  // last always equals the owner while granted, so one picker serves idle and release
  assign w_beat = r_state == GRANT && bus.req[r_owner];
  assign w_arb = r_state == IDLE || !w_beat || r_cnt == CW'(BURST_LEN - 1);
  // next state: arbitrate when idle or on release, otherwise count the beat
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last = r_last;
    w_sel = r_sel;
    w_gnt = r_gnt;
    w_cnt = r_cnt + 1'b1;
    if (w_arb && w_found) begin
      w_state = GRANT;
      w_owner = w_idx;
      w_last = w_idx;
      w_sel = w_idx;
      w_gnt = N_REQ'(1) << w_idx;
      w_cnt = '0;
    end else if (w_arb) begin
      w_state = IDLE;
      w_gnt = '0;
      w_cnt = '0;
    end
  end
  // state and outputs; valid/src lag one cycle to line up with the mux register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last <= SEL_W'(N_REQ - 1);
      r_sel <= '0;
      r_gnt <= '0;
      r_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_src <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last <= w_last;
      r_sel <= w_sel;
      r_gnt <= w_gnt;
      r_cnt <= w_cnt;
      r_out_valid <= |(r_gnt & bus.req);
      r_out_src <= r_sel;
    end
  assign bus.gnt = r_gnt;
  assign bus.sel = r_sel;
  assign bus.busy = r_state == GRANT;
  assign bus.out_valid = r_out_valid;
  assign bus.out_src = r_out_src;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed table plus randomized reference-model check of two arbiter configurations
module tb_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mux_arb_if b4();
  mux_arb_if b1();
  mux_arbiter #(.BURST_LEN(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_arbiter #(.BURST_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  int n_chk = 0;
  int n_fail = 0;
  int bl[2] = '{4, 1};
  int m_owner[2], m_last[2], m_cnt[2], m_sel[2], m_ov[2], m_os[2];
  typedef struct {logic [3:0] req; logic [9:0] exp;} vec_t;
  vec_t tbl[13];
  function automatic int pick(logic [3:0] r, int l);
    for (int k = 1; k <= 4; k++)
      if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction
  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d] = 3;
      m_cnt[d] = 0;
      m_sel[d] = 0;
      m_ov[d] = 0;
      m_os[d] = 0;
    end
  endtask
  task automatic m_step(int d, logic [3:0] r);
    int w;
    w = -2;
    m_ov[d] = (m_owner[d] >= 0 && r[m_owner[d]]) ? 1 : 0;
    m_os[d] = m_sel[d];
    if (m_owner[d] < 0) w = pick(r, m_last[d]);
    else if (!r[m_owner[d]]) w = pick(r, m_owner[d]);
    else begin
      m_cnt[d]++;
      if (m_cnt[d] == bl[d]) w = pick(r, m_owner[d]);
    end
    if (w >= 0) begin
      m_owner[d] = w;
      m_last[d] = w;
      m_sel[d] = w;
      m_cnt[d] = 0;
    end else if (w == -1) m_owner[d] = -1;
  endtask
  function automatic logic [9:0] m_exp(int d);
    logic [3:0] g;
    g = m_owner[d] >= 0 ? 4'(1 << m_owner[d]) : 4'b0;
    return {g, 2'(m_sel[d]), m_owner[d] >= 0, m_ov[d] != 0, 2'(m_os[d])};
  endfunction
  function automatic logic [9:0] act(int d);
    return d != 0 ? {b1.gnt, b1.sel, b1.busy, b1.out_valid, b1.out_src}
                  : {b4.gnt, b4.sel, b4.busy, b4.out_valid, b4.out_src};
  endfunction
  task automatic check(string name, logic [9:0] a, logic [9:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b", name, $time, a, e);
    end
  endtask
  task automatic cycle(logic [3:0] r4, logic [3:0] r1);
    b4.req = r4;
    b1.req = r1;
    m_step(0, r4);
    m_step(1, r1);
    @(posedge clk);
    @(negedge clk);
    check("model_bl4", act(0), m_exp(0));
    check("model_bl1", act(1), m_exp(1));
  endtask
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("async_rst_bl4", act(0), 10'b0);
    check("async_rst_bl1", act(1), 10'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    tbl = '{
      '{4'b0000, 10'b0000_00_0_0_00},
      '{4'b0101, 10'b0001_00_1_0_00},
      '{4'b0101, 10'b0001_00_1_1_00},
      '{4'b0101, 10'b0001_00_1_1_00},
      '{4'b0100, 10'b0100_10_1_0_00},
      '{4'b0100, 10'b0100_10_1_1_10},
      '{4'b0100, 10'b0100_10_1_1_10},
      '{4'b0100, 10'b0100_10_1_1_10},
      '{4'b0100, 10'b0100_10_1_1_10},
      '{4'b0000, 10'b0000_10_0_0_10},
      '{4'b0000, 10'b0000_10_0_0_10},
      '{4'b1000, 10'b1000_11_1_0_10},
      '{4'b1000, 10'b1000_11_1_1_11}
    };
    m_reset();
    b4.req = 4'b1111;
    b1.req = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_bl4", act(0), 10'b0);
    check("reset_bl1", act(1), 10'b0);
    rst = 1'b1;
    cycle(4'b1111, 4'b1111);
    check("first_gnt", {6'b0, b4.gnt}, 10'b0001);
    cycle(4'b1111, 4'b1111);
    check("first_valid", {9'b0, b4.out_valid}, 10'b1);
    async_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].req, 4'($urandom));
      check($sformatf("tbl%0d", i), act(0), tbl[i].exp);
    end
    for (int i = 0; i < 12; i++) cycle(4'b0001, 4'b1010);
    for (int i = 0; i < 20; i++) cycle(4'b1111, 4'b1010);
    cycle(4'b1000, 4'b1000);
    cycle(4'b1000, 4'b1000);
    async_reset();
    cycle(4'b1010, 4'b1010);
    check("post_reset_gnt", {6'b0, b4.gnt}, 10'b0010);
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1010, 4'b1010);
      check("bl1_alternate", {8'b0, b1.sel}, i % 2 == 0 ? 10'd3 : 10'd1);
    end
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom) | 4'($urandom), 4'($urandom));
      if (i == 200) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that sits directly upstream of the 4:1 registered mux stage and drives its `sel`. It chooses which of four requesters owns the datapath and holds that grant for up to `BURST_LEN` beats. It also emits `out_valid` and `out_src`, aligned to the mux stage's one-cycle registered output, so downstream logic knows when that output is meaningful and where it came from.

## Interface
- `BURST_LEN`, default 4: maximum consecutive beats per grant; legal range is 1 or more.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester request; bit i corresponds to mux input i.
- `sel`  out  2  select driven to the mux stage; registered.
- `gnt`  out  4  one-hot grant, or all zero; registered.
- `busy`  out  1  high while in GRANT; registered.
- `out_valid`  out  1  mux stage output holds a valid beat this cycle.
- `out_src`  out  2  index of the requester whose beat is on the mux output.

## Operation
- States: IDLE and GRANT. There is also an owner register, a `last` (most recent winner) register, and a beat counter of width max(1, $clog2(BURST_LEN)).
- Pick rule: the winner is the first set bit of `req`, searching upward from `(last+1) mod 4` with wrap-around. `last` resets to 3, so req0 has first priority out of reset.
- IDLE:
  - If `req` is non-zero, register the winner into owner/`last`, set `gnt`, `sel` and `busy`, clear the counter, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: a cycle is a beat when `req[owner]` is 1. On each beat the counter increments.
- Release happens when `req[owner]` is 0, or when a beat occurs with counter == BURST_LEN-1.
- On release, re-arbitrate at the same edge:
  - The pick rule is applied with `last` = current owner.
  - When BURST_LEN is reached, the current owner is eligible again but at lowest priority.
  - When release is caused by the owner dropping `req`, the owner's bit is 0 and it is excluded.
  - If there is a winner, the new grant takes effect with no idle bubble and the counter clears.
  - If there is none, return to IDLE with `gnt`=0 and `busy`=0.
- `sel` holds its last value in IDLE and never glitches to an unrequested index mid-burst.
- `out_valid` is the registered value of |(`gnt` & `req`). `out_src` is the registered `sel`.
- A single requester that stays active is re-granted at every burst boundary with continuous beats.

## Timing
- Reset values: `gnt`=0, `sel`=0, `busy`=0, `out_valid`=0, `out_src`=0, state=IDLE, counter=0, `last`=3.
- Reset asserted mid-burst clears all of the above asynchronously. The first grant after release goes to the lowest set index at or above 0.
- Latency:
  - `req` rising and sampled at edge t gives `gnt`/`sel` valid after edge t.
  - The mux stage captures at edge t+1.
  - `out_valid`/`out_src` are high after edge t+1, coincident with the mux output.
- Grant-to-grant hand-off has zero dead cycles. `out_valid` has a gap only for cycles where the owner's `req` is low.
- BURST_LEN=1 re-arbitrates after every beat, giving pure round robin.
- Simultaneous owner drop and burst limit: treated as a single release.

## Structure
- Shared package `mux_arb_pkg`: `N_REQ`=4, `SEL_W`=2, state enum {IDLE, GRANT}.
- Sub-module `rr_pick`: purely combinational. Inputs are `req[3:0]` and `last[1:0]`. Outputs are `found` and `idx[1:0]`. The top instantiates it once.
- Top: state register, owner/`last`, counter, output registers.

## Test plan
- Reset check: hold `rst`=0 with `req`=4'b1111 → all outputs 0. Release `rst` → `gnt`=0001, `sel`=0 after the next edge; `out_valid`=1 one edge later.
- Single requester, `req`=0001 held for 12 cycles, BURST_LEN=4 → `gnt`=0001 continuously, counter wraps at 3 three times, `out_valid` high for 12 cycles with no gap, `out_src`=0.
- All requesting, `req`=1111, BURST_LEN=4 → `sel` sequence 0×4, 1×4, 2×4, 3×4, 0…; `out_src` repeats the same sequence delayed by exactly one cycle.
- Early drop: req0 granted with req2 pending; drop req0 after 2 beats → `gnt`=0100 at the next edge, counter=0, then req2 receives 4 beats.
- Async reset mid-burst: assert `rst` between edges during req3's burst → outputs clear immediately without a clock edge. Release with `req`=1010 → req1 is granted first.
- BURST_LEN=1 with `req`=1010 held → `sel` alternates 1,3,1,3 every cycle; `out_valid` stays continuously high.
